// File: rtl/morse_symbol_buffer.sv
// rtl/morse_symbol_buffer.sv - collects dot/dash symbols into a letter pattern and hands it downstream
// Optional left-aligned output: define MORSE_SYMBUF_LEFT_ALIGN_EN.
module morse_symbol_buffer #(
  parameter int WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sym_valid,
  input  logic                         sym_bit,
  input  logic                         letter_end,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_pattern,
  output logic [$clog2(WIDTH+1)-1:0]   out_len,
  output logic                         out_ovf,
  output logic                         drop
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LEN_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pattern;
  logic [CW-1:0]    r_len;
  logic             r_ovf;

  logic             w_open;
  logic             w_close;
  logic [WIDTH-1:0] w_pat_nxt;
  logic [CW-1:0]    w_len_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_pat_out;

  assign w_open   = (r_state != HOLD);
  assign in_ready = w_open;

  // Symbol is folded in before the close decision so a simultaneous strobe lands in the letter.
  always_comb begin
    w_pat_nxt = r_pattern;
    w_len_nxt = r_len;
    w_ovf_nxt = r_ovf;
    if (sym_valid && w_open) begin
      if (r_len < LEN_MAX) begin
        w_pat_nxt = {r_pattern[WIDTH-2:0], sym_bit};
        w_len_nxt = r_len + CW'(1);
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  assign w_close = letter_end && w_open && (w_len_nxt != '0);

`ifdef MORSE_SYMBUF_LEFT_ALIGN_EN
  logic [CW-1:0] w_shift;
  assign w_shift   = LEN_MAX - w_len_nxt;
  assign w_pat_out = w_pat_nxt << w_shift;
`else
  assign w_pat_out = w_pat_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pattern   <= '0;
      r_len       <= '0;
      r_ovf       <= 1'b0;
      out_valid   <= 1'b0;
      out_pattern <= '0;
      out_len     <= '0;
      out_ovf     <= 1'b0;
      drop        <= 1'b0;
    end else begin
      drop <= !w_open && (sym_valid || letter_end);
      case (r_state)
        IDLE, COLLECT: begin
          r_pattern <= w_pat_nxt;
          r_len     <= w_len_nxt;
          r_ovf     <= w_ovf_nxt;
          if (w_close) begin
            r_state     <= HOLD;
            out_valid   <= 1'b1;
            out_pattern <= w_pat_out;
            out_len     <= w_len_nxt;
            out_ovf     <= w_ovf_nxt;
          end else if (w_len_nxt != '0) begin
            r_state <= COLLECT;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_pattern   <= '0;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            out_valid   <= 1'b0;
            out_pattern <= '0;
            out_len     <= '0;
            out_ovf     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_buffer.sv
// tb/tb_morse_symbol_buffer.sv - scoreboard bench for morse_symbol_buffer
module tb_morse_symbol_buffer;

  localparam int W  = 5;
  localparam int CW = $clog2(W+1);

  typedef struct packed {
    logic [W-1:0]  p;
    logic [CW-1:0] l;
    logic          o;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, sym_valid, sym_bit, letter_end, out_ready;
  logic          in_ready, out_valid, out_ovf, drop;
  logic [W-1:0]  out_pattern;
  logic [CW-1:0] out_len;

  exp_t     sb[$];
  int       n_vec = 0;
  int       n_err = 0;
  bit       seen_valid = 0;
  logic [W-1:0] m_pat;
  int       m_len;
  bit       m_ovf;
  int       drop_cnt;

  morse_symbol_buffer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_bit(sym_bit),
    .letter_end(letter_end), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_pattern(out_pattern), .out_len(out_len),
    .out_ovf(out_ovf), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] align(input logic [W-1:0] p, input int l);
`ifdef MORSE_SYMBUF_LEFT_ALIGN_EN
    return p << (W - l);
`else
    return p;
`endif
  endfunction

  task automatic m_sym(input logic b);
    if (m_len < W) begin
      m_pat = {m_pat[W-2:0], b};
      m_len++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic m_push();
    exp_t e;
    e.p = align(m_pat, m_len);
    e.l = CW'(m_len);
    e.o = m_ovf;
    sb.push_back(e);
    m_pat = '0;
    m_len = 0;
    m_ovf = 1'b0;
  endtask

  task automatic send_sym(input logic b);
    sym_valid = 1'b1;
    sym_bit   = b;
    m_sym(b);
    tick();
    sym_valid = 1'b0;
  endtask

  // Closes the current letter; with out_ready high also completes the transfer.
  task automatic close_letter(input string tag);
    letter_end = 1'b1;
    m_push();
    tick();
    letter_end = 1'b0;
    check({tag, "_lat"}, out_valid, 1);
    if (out_ready) begin
      tick();
      check({tag, "_done"}, out_valid, 0);
      check({tag, "_rdy"}, in_ready, 1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_pattern"}, out_pattern, 0);
    check({tag, "_len"}, out_len, 0);
    check({tag, "_ovf"}, out_ovf, 0);
    check({tag, "_drop"}, drop, 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) seen_valid = 1;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pattern", out_pattern, e.p);
        check("sb_len", out_len, e.l);
        check("sb_ovf", out_ovf, e.o);
      end
    end
  end

  initial begin
    reset = 1'b1; sym_valid = 1'b0; sym_bit = 1'b0; letter_end = 1'b0; out_ready = 1'b1;
    m_pat = '0; m_len = 0; m_ovf = 1'b0;
    tick(); tick();
    check_reset_state("rst");
    reset = 1'b0;
    tick();

    // Basic letter 0,1,1
    send_sym(0); send_sym(1); send_sym(1);
    close_letter("t1");

    // Overflow by six dashes, then a clean single dot
    for (int i = 0; i < 6; i++) send_sym(1);
    close_letter("t3a");
    send_sym(0);
    close_letter("t3b");

    // Backpressure with a dropped strobe
    out_ready = 1'b0;
    send_sym(1); send_sym(0);
    close_letter("t4");
    drop_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      check("t4_hold_valid", out_valid, 1);
      check("t4_in_ready", in_ready, 0);
      check("t4_hold_pat", out_pattern, align(5'b00010, 2));
      check("t4_hold_len", out_len, 2);
      sym_valid = (c == 2);
      sym_bit   = 1'b1;
      tick();
      sym_valid = 1'b0;
      if (drop) drop_cnt++;
    end
    check("t4_drop_cnt", drop_cnt, 1);
    out_ready = 1'b1;
    tick();
    check("t4_xfer_valid", out_valid, 0);
    check("t4_xfer_rdy", in_ready, 1);

    // letter_end in IDLE, then symbol with letter_end together
    letter_end = 1'b1;
    tick();
    letter_end = 1'b0;
    tick();
    check("t5_empty", out_valid, 0);
    sym_valid = 1'b1; sym_bit = 1'b1; letter_end = 1'b1;
    m_sym(1); m_push();
    tick();
    sym_valid = 1'b0; letter_end = 1'b0;
    check("t5_lat", out_valid, 1);
    tick();

    // Every length from 1 to W+1 with random symbols
    for (int n = 1; n <= W + 1; n++) begin
      for (int k = 0; k < n; k++) send_sym(1'($urandom_range(0, 1)));
      close_letter("len_sweep");
    end

    // Reset mid-letter and in HOLD
    send_sym(1); send_sym(1); send_sym(0);
    seen_valid = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("t6a");
    m_pat = '0; m_len = 0; m_ovf = 1'b0;
    tick(); tick();
    check("t6a_no_valid", seen_valid, 0);
    out_ready = 1'b0;
    send_sym(0); send_sym(1);
    letter_end = 1'b1;
    tick();
    letter_end = 1'b0;
    check("t6b_hold", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("t6b");
    m_pat = '0; m_len = 0; m_ovf = 1'b0;
    seen_valid = 0;
    tick(); tick();
    check("t6b_no_valid", seen_valid, 0);
    out_ready = 1'b1;
    send_sym(0);
    close_letter("t6c");

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
